// File: rtl/knn_dist_unit.sv
// KNN helper: a capture/pass-through register for a sample value, and a
// combinational squared Euclidean distance between two signed 2-D points.
module knn_dist_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              KNN_ENABLE,
   input  logic [DATA_W-1:0] KNN_DATA_IN,
   output logic [DATA_W-1:0] KNN_DATA_OUT,
   input  logic [DATA_W-1:0] DATA_X1,
   input  logic [DATA_W-1:0] DATA_X2,
   input  logic [DATA_W-1:0] DATA_Y1,
   input  logic [DATA_W-1:0] DATA_Y2,
   output logic [DATA_W-1:0] DATA_OUT
);

   localparam int DIFF_W = DATA_W + 1;
   localparam int SQ_W   = 2 * DATA_W + 2;
   localparam int SUM_W  = 2 * DATA_W + 3;

   logic [DATA_W-1:0] hold_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_reg <= '0;
      end else if (KNN_ENABLE) begin
         hold_reg <= KNN_DATA_IN;
      end
   end

   // Output is forced low during reset so the live path cannot leak through.
   always_comb begin
      KNN_DATA_OUT = '0;
      if (!rst) begin
         KNN_DATA_OUT = KNN_ENABLE ? KNN_DATA_IN : hold_reg;
      end
   end

   logic signed [DIFF_W-1:0] dx;
   logic signed [DIFF_W-1:0] dy;
   logic        [DIFF_W-1:0] abs_dx;
   logic        [DIFF_W-1:0] abs_dy;
   logic        [SQ_W-1:0]   sq_x;
   logic        [SQ_W-1:0]   sq_y;
   logic        [SUM_W-1:0]  dist_sum;

   // Sign-extend before subtracting so the difference never overflows; the
   // magnitude of a DIFF_W-bit value (at most 2^DATA_W) still fits in DIFF_W bits.
   always_comb begin
      dx       = $signed({DATA_X1[DATA_W-1], DATA_X1}) - $signed({DATA_X2[DATA_W-1], DATA_X2});
      dy       = $signed({DATA_Y1[DATA_W-1], DATA_Y1}) - $signed({DATA_Y2[DATA_W-1], DATA_Y2});
      abs_dx   = dx[DIFF_W-1] ? DIFF_W'(-dx) : DIFF_W'(dx);
      abs_dy   = dy[DIFF_W-1] ? DIFF_W'(-dy) : DIFF_W'(dy);
      sq_x     = {{(SQ_W-DIFF_W){1'b0}}, abs_dx} * {{(SQ_W-DIFF_W){1'b0}}, abs_dx};
      sq_y     = {{(SQ_W-DIFF_W){1'b0}}, abs_dy} * {{(SQ_W-DIFF_W){1'b0}}, abs_dy};
      dist_sum = {1'b0, sq_x} + {1'b0, sq_y};
   end

   assign DATA_OUT = (|dist_sum[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : dist_sum[DATA_W-1:0];

endmodule

// File: tb/tb_knn_dist_unit.sv
// Directed self-checking bench for knn_dist_unit: capture/hold, async reset,
// distance sweep, signed/symmetry cases and saturation.
module tb_knn_dist_unit;

   localparam int DATA_W = 32;

   logic              clk;
   logic              rst;
   logic              KNN_ENABLE;
   logic [DATA_W-1:0] KNN_DATA_IN;
   logic [DATA_W-1:0] KNN_DATA_OUT;
   logic [DATA_W-1:0] DATA_X1;
   logic [DATA_W-1:0] DATA_X2;
   logic [DATA_W-1:0] DATA_Y1;
   logic [DATA_W-1:0] DATA_Y2;
   logic [DATA_W-1:0] DATA_OUT;

   int checks;
   int errors;

   knn_dist_unit #(.DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .KNN_ENABLE   (KNN_ENABLE),
      .KNN_DATA_IN  (KNN_DATA_IN),
      .KNN_DATA_OUT (KNN_DATA_OUT),
      .DATA_X1      (DATA_X1),
      .DATA_X2      (DATA_X2),
      .DATA_Y1      (DATA_Y1),
      .DATA_Y2      (DATA_Y2),
      .DATA_OUT     (DATA_OUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst         = 1'b1;
      KNN_ENABLE  = 1'b1;
      KNN_DATA_IN = 32'd123;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      $display("reset: knn_out=%0d", KNN_DATA_OUT);
      if (KNN_DATA_OUT !== 32'd0) begin
         errors++;
         $display("FAIL reset_out got=%0h exp=0", KNN_DATA_OUT);
      end
   endtask

   task automatic test_passthrough();
      @(negedge clk);
      rst         = 1'b0;
      KNN_ENABLE  = 1'b0;
      #1;
      checks++;
      $display("post_reset: knn_out=%0d", KNN_DATA_OUT);
      if (KNN_DATA_OUT !== 32'd0) begin
         errors++;
         $display("FAIL post_reset_hold got=%0h exp=0", KNN_DATA_OUT);
      end
      KNN_ENABLE  = 1'b1;
      KNN_DATA_IN = 32'd69;
      #1;
      checks++;
      $display("passthrough: knn_out=%0d", KNN_DATA_OUT);
      if (KNN_DATA_OUT !== 32'd69) begin
         errors++;
         $display("FAIL passthrough got=%0d exp=69", KNN_DATA_OUT);
      end
   endtask

   task automatic test_hold();
      @(posedge clk);
      @(negedge clk);
      KNN_ENABLE  = 1'b0;
      KNN_DATA_IN = 32'd5;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         $display("hold cycle %0d: knn_out=%0d", c, KNN_DATA_OUT);
         if (KNN_DATA_OUT !== 32'd69) begin
            errors++;
            $display("FAIL hold_c%0d got=%0d exp=69", c, KNN_DATA_OUT);
         end
      end
   endtask

   task automatic test_async_reset();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      $display("async_reset: knn_out=%0d", KNN_DATA_OUT);
      if (KNN_DATA_OUT !== 32'd0) begin
         errors++;
         $display("FAIL async_reset got=%0d exp=0", KNN_DATA_OUT);
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      $display("after_reset_release: knn_out=%0d", KNN_DATA_OUT);
      if (KNN_DATA_OUT !== 32'd0) begin
         errors++;
         $display("FAIL held_discarded got=%0d exp=0", KNN_DATA_OUT);
      end
   endtask

   task automatic test_reset_edge_no_load();
      @(negedge clk);
      rst         = 1'b1;
      KNN_ENABLE  = 1'b1;
      KNN_DATA_IN = 32'd77;
      #1;
      checks++;
      if (KNN_DATA_OUT !== 32'd0) begin
         errors++;
         $display("FAIL reset_overrides_enable got=%0d exp=0", KNN_DATA_OUT);
      end
      @(posedge clk);
      @(negedge clk);
      rst        = 1'b0;
      KNN_ENABLE = 1'b0;
      #1;
      checks++;
      $display("reset_edge_no_load: knn_out=%0d", KNN_DATA_OUT);
      if (KNN_DATA_OUT !== 32'd0) begin
         errors++;
         $display("FAIL reset_edge_no_load got=%0d exp=0", KNN_DATA_OUT);
      end
      KNN_DATA_IN = 32'd99;
      #1;
      checks++;
      if (KNN_DATA_OUT !== 32'd0) begin
         errors++;
         $display("FAIL in_change_while_disabled got=%0d exp=0", KNN_DATA_OUT);
      end
   endtask

   task automatic test_distance_sweep();
      logic [DATA_W-1:0] exp_d;
      for (int i = 1; i <= 9; i++) begin
         DATA_X1 = 32'(i);
         DATA_Y1 = 32'(i);
         DATA_X2 = 32'(2 * i);
         DATA_Y2 = 32'(2 * i);
         exp_d   = 32'(2 * i * i);
         #1;
         checks++;
         $display("sweep i=%0d: dist=%0d", i, DATA_OUT);
         if (DATA_OUT !== exp_d) begin
            errors++;
            $display("FAIL sweep_i%0d got=%0d exp=%0d", i, DATA_OUT, exp_d);
         end
      end
   endtask

   task automatic test_signed_symmetry();
      DATA_X1 = 32'hFFFF_FFFD;
      DATA_X2 = 32'd4;
      DATA_Y1 = 32'd0;
      DATA_Y2 = 32'd0;
      #1;
      checks++;
      $display("signed: dist=%0d", DATA_OUT);
      if (DATA_OUT !== 32'd49) begin
         errors++;
         $display("FAIL signed_dx got=%0d exp=49", DATA_OUT);
      end
      DATA_X1 = 32'd4;
      DATA_X2 = 32'hFFFF_FFFD;
      #1;
      checks++;
      $display("swapped: dist=%0d", DATA_OUT);
      if (DATA_OUT !== 32'd49) begin
         errors++;
         $display("FAIL swapped got=%0d exp=49", DATA_OUT);
      end
      DATA_X1 = 32'd7;
      DATA_X2 = 32'd7;
      DATA_Y1 = 32'd7;
      DATA_Y2 = 32'd7;
      #1;
      checks++;
      $display("identical: dist=%0d", DATA_OUT);
      if (DATA_OUT !== 32'd0) begin
         errors++;
         $display("FAIL identical got=%0d exp=0", DATA_OUT);
      end
      // Largest non-saturating case: 65535^2 + 0 fits, 65536^2 does not.
      DATA_X1 = 32'd65535;
      DATA_X2 = 32'd0;
      DATA_Y1 = 32'd0;
      DATA_Y2 = 32'd0;
      #1;
      checks++;
      $display("near_max: dist=%0h", DATA_OUT);
      if (DATA_OUT !== 32'hFFFE_0001) begin
         errors++;
         $display("FAIL near_max got=%0h exp=fffe0001", DATA_OUT);
      end
      DATA_X1 = 32'd65536;
      #1;
      checks++;
      $display("just_over: dist=%0h", DATA_OUT);
      if (DATA_OUT !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL just_over got=%0h exp=ffffffff", DATA_OUT);
      end
   endtask

   task automatic test_saturation();
      DATA_X1 = 32'h7FFF_FFFF;
      DATA_X2 = 32'h8000_0000;
      DATA_Y1 = 32'd0;
      DATA_Y2 = 32'd0;
      #1;
      checks++;
      $display("saturation: dist=%0h", DATA_OUT);
      if (DATA_OUT !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL saturation got=%0h exp=ffffffff", DATA_OUT);
      end
   endtask

   task automatic test_reset_independence();
      @(negedge clk);
      rst     = 1'b1;
      DATA_X1 = 32'd3;
      DATA_X2 = 32'd0;
      DATA_Y1 = 32'd4;
      DATA_Y2 = 32'd0;
      @(posedge clk);
      #1;
      checks++;
      $display("reset_independence: dist=%0d", DATA_OUT);
      if (DATA_OUT !== 32'd25) begin
         errors++;
         $display("FAIL reset_indep got=%0d exp=25", DATA_OUT);
      end
      rst = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      KNN_ENABLE  = 1'b0;
      KNN_DATA_IN = '0;
      DATA_X1     = '0;
      DATA_X2     = '0;
      DATA_Y1     = '0;
      DATA_Y2     = '0;
      test_reset();
      test_passthrough();
      test_hold();
      test_async_reset();
      test_reset_edge_no_load();
      test_distance_sweep();
      test_signed_symmetry();
      test_saturation();
      test_reset_independence();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/knn_dist_unit.md
KNN_DIST_UNIT -- requirements
Module: knn_dist_unit

Interface
REQ-001 Parameter DATA_W, default 32, width of every data port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 KNN_ENABLE  input  1  enables capture and pass-through of KNN_DATA_IN.
REQ-005 KNN_DATA_IN  input  DATA_W  value to capture.
REQ-006 KNN_DATA_OUT  output  DATA_W  live or held captured value.
REQ-007 DATA_X1, DATA_X2  input  DATA_W each  x-coordinates of points 1 and 2, signed two's complement.
REQ-008 DATA_Y1, DATA_Y2  input  DATA_W each  y-coordinates of points 1 and 2, signed two's complement.
REQ-009 DATA_OUT  output  DATA_W  unsigned squared Euclidean distance.
REQ-010 The block SHALL use one clock (clk); reset (rst) SHALL be asynchronous and active-high.

Function -- capture path
REQ-011 The block SHALL contain one DATA_W-bit holding register HOLD.
REQ-012 HOLD SHALL load KNN_DATA_IN on each rising clk edge with KNN_ENABLE=1 and rst=0.
REQ-013 HOLD SHALL keep its value on rising edges with KNN_ENABLE=0.
REQ-014 While rst=0 and KNN_ENABLE=1, KNN_DATA_OUT SHALL equal KNN_DATA_IN combinationally, with zero cycles of latency.
REQ-015 While rst=0 and KNN_ENABLE=0, KNN_DATA_OUT SHALL equal HOLD.
REQ-016 KNN_DATA_IN changes while KNN_ENABLE=0 SHALL NOT affect KNN_DATA_OUT.

Function -- distance path
REQ-017 The distance path SHALL be purely combinational and independent of clk, rst and KNN_ENABLE.
REQ-018 dx = DATA_X1 - DATA_X2 and dy = DATA_Y1 - DATA_Y2 SHALL be computed signed at DATA_W+1 bits, so no difference overflows.
REQ-019 dx*dx and dy*dy SHALL be computed unsigned at 2*DATA_W+2 bits.
REQ-020 The two squares SHALL be summed at 2*DATA_W+3 bits.
REQ-021 DATA_OUT SHALL equal the sum when the sum is at most 2^DATA_W - 1.
REQ-022 Otherwise DATA_OUT SHALL saturate to all ones (0xFFFFFFFF for DATA_W=32).
REQ-023 Identical points SHALL give DATA_OUT=0.
REQ-024 Swapping point 1 and point 2 SHALL give an identical DATA_OUT.

Reset
REQ-025 Asserting rst SHALL clear HOLD to 0 immediately, without waiting for a clock edge.
REQ-026 While rst=1, KNN_DATA_OUT SHALL be 0 regardless of KNN_ENABLE and KNN_DATA_IN.
REQ-027 rst asserted mid-operation SHALL discard the held value; after release, KNN_DATA_OUT SHALL be 0 until a capture occurs or KNN_ENABLE=1.
REQ-028 A rising edge coinciding with rst=1 SHALL NOT load HOLD.
REQ-029 DATA_OUT SHALL NOT be affected by rst.

Verification
REQ-030 Pass-through: after reset release, KNN_ENABLE=1, KNN_DATA_IN=69 -> KNN_DATA_OUT=69 in the same timestep.
REQ-031 Hold:
  - capture 69 with KNN_ENABLE=1, then KNN_ENABLE=0, KNN_DATA_IN=5 for 3 cycles -> KNN_DATA_OUT stays 69;
  - then rst pulse -> KNN_DATA_OUT=0 asynchronously.
REQ-032 Distance sweep: for i=1..9, X1=Y1=i, X2=Y2=2i -> DATA_OUT=2*i*i (2, 8, 18, ..., 162).
REQ-033 Signed and symmetry checks:
  - X1=-3, X2=4, Y1=Y2=0 -> DATA_OUT=49;
  - swapped points -> 49;
  - all inputs 7 -> 0.
REQ-034 Saturation: X1=0x7FFFFFFF, X2=0x80000000, Y1=Y2=0 -> DATA_OUT=0xFFFFFFFF.
REQ-035 Reset independence: rst held high with X1=3, X2=0, Y1=4, Y2=0 -> DATA_OUT=25.
